// File: rtl/id_branch_ctrl_if.sv
// Fetch/EX-facing signal bundle for the ID branch controller; slave = ID stage, master = its environment.
// HAZARD_STATS_EN adds the stall/flush counter outputs.
interface id_branch_ctrl_if;
    logic [31:0] PC_in;
    logic [31:0] Instruction_in;
    logic        ext_stall;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  ex_dest;
    logic        mem_mem_read;
    logic [4:0]  mem_dest;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        freeze;
    logic        Branch_taken;
    logic [31:0] BranchAddr;
    logic [31:0] PC_out;
    logic [31:0] Instruction_out;
    logic        valid_out;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count;
    logic [15:0] flush_count;
`endif

    modport slave (
        input  PC_in, Instruction_in, ext_stall, rs_val, rt_val,
               ex_reg_write, ex_mem_read, ex_dest, mem_mem_read, mem_dest,
        output rs_addr, rt_addr, freeze, Branch_taken, BranchAddr,
               PC_out, Instruction_out, valid_out
`ifdef HAZARD_STATS_EN
             , stall_count, flush_count
`endif
    );

    modport master (
        output PC_in, Instruction_in, ext_stall, rs_val, rt_val,
               ex_reg_write, ex_mem_read, ex_dest, mem_mem_read, mem_dest,
        input  rs_addr, rt_addr, freeze, Branch_taken, BranchAddr,
               PC_out, Instruction_out, valid_out
`ifdef HAZARD_STATS_EN
             , stall_count, flush_count
`endif
    );
endinterface

// File: rtl/id_branch_ctrl.sv
// IF/ID register + ID-stage hazard detection and branch resolution; fetch->EX latency 1 cycle, taken branch costs 1 bubble.
// Backpressure: hazards raise freeze and hold IF/ID; ext_stall holds everything. HAZARD_STATS_EN adds saturating stall/flush counters.
module id_branch_ctrl #(
    parameter logic [5:0] OP_BEQ = 6'd10,
    parameter logic [5:0] OP_BNE = 6'd11,
    parameter logic [5:0] OP_JMP = 6'd12,
    parameter logic [5:0] OP_LD  = 6'd4
) (
    input  logic              clk,
    input  logic              rst,
    id_branch_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [31:0] imm_sext;
    logic        is_beq, is_bne, is_jmp, is_br;
    logic        uses_rs, uses_rt;
    logic        load_use, br_hazard, hazard, take, ops_eq;

    assign op       = instr_q[31:26];
    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign imm_sext = {{16{instr_q[15]}}, instr_q[15:0]};
    assign is_beq   = (op == OP_BEQ);
    assign is_bne   = (op == OP_BNE);
    assign is_jmp   = (op == OP_JMP);
    assign is_br    = is_beq | is_bne;
    assign uses_rs  = !is_jmp && (instr_q != 32'd0);
    assign uses_rt  = (op == 6'd0) || is_br;

    // Loads are recognised from the EX/MEM flags, never from OP_LD in ID.
    assign load_use  = bus.ex_mem_read && (bus.ex_dest != 5'd0) &&
                       ((uses_rs && bus.ex_dest == rs) || (uses_rt && bus.ex_dest == rt));
    assign br_hazard = is_br &&
                       ((bus.ex_reg_write && bus.ex_dest != 5'd0 &&
                         (bus.ex_dest == rs || bus.ex_dest == rt)) ||
                        (bus.mem_mem_read && bus.mem_dest != 5'd0 &&
                         (bus.mem_dest == rs || bus.mem_dest == rt)));
    assign hazard    = valid_q && (load_use || br_hazard);
    assign ops_eq    = (bus.rs_val == bus.rt_val);
    assign take      = valid_q && !hazard && !bus.ext_stall &&
                       (is_jmp || (is_beq && ops_eq) || (is_bne && !ops_eq));

    assign bus.rs_addr         = rs;
    assign bus.rt_addr         = rt;
    assign bus.freeze          = hazard && !bus.ext_stall;
    assign bus.Branch_taken    = take;
    assign bus.BranchAddr      = take ? (pc_q + imm_sext) : 32'd0;
    assign bus.valid_out       = valid_q && !hazard && !bus.ext_stall;
    assign bus.Instruction_out = bus.valid_out ? instr_q : 32'd0;
    assign bus.PC_out          = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (!bus.ext_stall) begin
            if (hazard) begin
                state_d = STALL;
            end else if (take) begin
                // The instruction fetched alongside a taken branch is wrong-path.
                pc_d    = bus.PC_in;
                instr_d = 32'd0;
                valid_d = 1'b0;
                state_d = FLUSH;
            end else begin
                pc_d    = bus.PC_in;
                instr_d = bus.Instruction_in;
                valid_d = 1'b1;
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= 32'd0;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.freeze && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
        if (take && flush_cnt_q != 16'hFFFF)       flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;
`endif
endmodule

// File: tb/tb_id_branch_ctrl.sv
// Directed bench for id_branch_ctrl: vector table for single-cycle decode/hazard/branch cases plus multi-cycle sequences.
module tb_id_branch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    id_branch_ctrl_if bus();
    id_branch_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic        exw;
        logic        exr;
        logic [4:0]  exd;
        logic        mmr;
        logic [4:0]  mmd;
        logic        xst;
        logic        e_frz;
        logic        e_tk;
        logic [31:0] e_ba;
        logic        e_vld;
    } vec_t;

    vec_t v[19];

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clr_side();
        bus.ext_stall    = 1'b0;
        bus.rs_val       = 32'd0;
        bus.rt_val       = 32'd0;
        bus.ex_reg_write = 1'b0;
        bus.ex_mem_read  = 1'b0;
        bus.ex_dest      = 5'd0;
        bus.mem_mem_read = 1'b0;
        bus.mem_dest     = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    logic [31:0] a_i, b_i, c_i, d_i;

    initial begin
        v[0]  = '{32'd1,        mk(6'd0, 5'd1, 5'd2, 16'h0800),  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0,   1};
        v[1]  = '{32'd5,        mk(6'd10, 5'd1, 5'd2, 16'hFFFD), 7, 7, 0, 0, 0, 0, 0, 0, 0, 1, 32'd2,   1};
        v[2]  = '{32'd5,        mk(6'd10, 5'd1, 5'd2, 16'hFFFD), 7, 8, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0,   1};
        v[3]  = '{32'h20,       mk(6'd11, 5'd1, 5'd2, 16'h0010), 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 32'h30,  1};
        v[4]  = '{32'h20,       mk(6'd11, 5'd1, 5'd2, 16'h0010), 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0,   1};
        v[5]  = '{32'hFFFFFFFE, mk(6'd12, 5'd0, 5'd0, 16'h0004), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd2,   1};
        v[6]  = '{32'd1,        mk(6'd0, 5'd3, 5'd2, 16'h0000),  0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 32'd0,   0};
        v[7]  = '{32'd1,        mk(6'd0, 5'd1, 5'd3, 16'h0000),  0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 32'd0,   0};
        v[8]  = '{32'd1,        mk(6'd4, 5'd1, 5'd3, 16'h0000),  0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 32'd0,   1};
        v[9]  = '{32'd1,        mk(6'd0, 5'd0, 5'd0, 16'h0800),  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'd0,   1};
        v[10] = '{32'd9,        mk(6'd10, 5'd4, 5'd5, 16'h0001), 5, 5, 1, 0, 5, 0, 0, 0, 1, 0, 32'd0,   0};
        v[11] = '{32'd9,        mk(6'd11, 5'd4, 5'd5, 16'h0001), 1, 2, 0, 0, 0, 1, 4, 0, 1, 0, 32'd0,   0};
        v[12] = '{32'd1,        mk(6'd0, 5'd4, 5'd6, 16'h0000),  0, 0, 1, 0, 4, 0, 0, 0, 0, 0, 32'd0,   1};
        v[13] = '{32'd10,       mk(6'd12, 5'd3, 5'd3, 16'h0005), 0, 0, 0, 1, 3, 0, 0, 0, 0, 1, 32'd15,  1};
        v[14] = '{32'd9,        mk(6'd10, 5'd4, 5'd5, 16'h0001), 5, 5, 1, 0, 5, 0, 0, 1, 0, 0, 32'd0,   0};
        v[15] = '{32'd1,        mk(6'd0, 5'd1, 5'd2, 16'h0000),  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'd0,   0};
        v[16] = '{32'd100,      mk(6'd11, 5'd0, 5'd0, 16'h0001), 1, 2, 0, 0, 0, 1, 0, 0, 0, 1, 32'd101, 1};
        v[17] = '{32'd3,        mk(6'd10, 5'd6, 5'd7, 16'h0002), 0, 0, 0, 0, 0, 1, 7, 0, 1, 0, 32'd0,   0};
        v[18] = '{32'd1,        mk(6'd0, 5'd5, 5'd1, 16'h0000),  0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 32'd0,   1};

        // Reset: outputs stay zero even with busy inputs and a clock edge.
        bus.PC_in          = 32'h1234;
        bus.Instruction_in = mk(6'd10, 5'd1, 5'd2, 16'h0005);
        bus.ext_stall      = 1'b0;
        bus.rs_val         = 32'd1;
        bus.rt_val         = 32'd1;
        bus.ex_reg_write   = 1'b1;
        bus.ex_mem_read    = 1'b1;
        bus.ex_dest        = 5'd1;
        bus.mem_mem_read   = 1'b1;
        bus.mem_dest       = 5'd2;
        step();
        chk("rst freeze", {31'd0, bus.freeze}, 32'd0);
        chk("rst taken", {31'd0, bus.Branch_taken}, 32'd0);
        chk("rst baddr", bus.BranchAddr, 32'd0);
        chk("rst pc_out", bus.PC_out, 32'd0);
        chk("rst instr_out", bus.Instruction_out, 32'd0);
        chk("rst valid", {31'd0, bus.valid_out}, 32'd0);
        chk("rst rs_addr", {27'd0, bus.rs_addr}, 32'd0);
        chk("rst rt_addr", {27'd0, bus.rt_addr}, 32'd0);
        rst = 1'b1;
        clr_side();

        // Straight-line ADDs.
        for (int i = 1; i <= 3; i++) begin
            a_i = mk(6'd0, 5'(i), 5'(i + 1), 16'h0800);
            bus.PC_in          = 32'(i);
            bus.Instruction_in = a_i;
            step();
            chk($sformatf("line%0d instr", i), bus.Instruction_out, a_i);
            chk($sformatf("line%0d pc", i), bus.PC_out, 32'(i));
            chk($sformatf("line%0d valid", i), {31'd0, bus.valid_out}, 32'd1);
            chk($sformatf("line%0d freeze", i), {31'd0, bus.freeze}, 32'd0);
            chk($sformatf("line%0d taken", i), {31'd0, bus.Branch_taken}, 32'd0);
        end

        // Vector table: load one instruction into IF/ID, then apply side inputs.
        for (int k = 0; k < 19; k++) begin
            clr_side();
            rst_pulse();
            bus.PC_in          = v[k].pc;
            bus.Instruction_in = v[k].instr;
            step();
            bus.rs_val       = v[k].rsv;
            bus.rt_val       = v[k].rtv;
            bus.ex_reg_write = v[k].exw;
            bus.ex_mem_read  = v[k].exr;
            bus.ex_dest      = v[k].exd;
            bus.mem_mem_read = v[k].mmr;
            bus.mem_dest     = v[k].mmd;
            bus.ext_stall    = v[k].xst;
            #1;
            chk($sformatf("vec%0d freeze", k), {31'd0, bus.freeze}, {31'd0, v[k].e_frz});
            chk($sformatf("vec%0d taken", k), {31'd0, bus.Branch_taken}, {31'd0, v[k].e_tk});
            chk($sformatf("vec%0d baddr", k), bus.BranchAddr, v[k].e_ba);
            chk($sformatf("vec%0d valid", k), {31'd0, bus.valid_out}, {31'd0, v[k].e_vld});
            chk($sformatf("vec%0d instr", k), bus.Instruction_out, v[k].e_vld ? v[k].instr : 32'd0);
            chk($sformatf("vec%0d pc", k), bus.PC_out, v[k].pc);
            chk($sformatf("vec%0d rs_addr", k), {27'd0, bus.rs_addr}, {27'd0, v[k].instr[25:21]});
            chk($sformatf("vec%0d rt_addr", k), {27'd0, bus.rt_addr}, {27'd0, v[k].instr[20:16]});
        end

        // Taken BEQ, one bubble, then normal flow.
        clr_side();
        rst_pulse();
        bus.PC_in          = 32'd5;
        bus.Instruction_in = mk(6'd10, 5'd1, 5'd2, 16'hFFFD);
        step();
        bus.rs_val = 32'd7;
        bus.rt_val = 32'd7;
        #1;
        chk("beq taken", {31'd0, bus.Branch_taken}, 32'd1);
        chk("beq baddr", bus.BranchAddr, 32'd2);
        bus.PC_in          = 32'd6;
        bus.Instruction_in = mk(6'd0, 5'd9, 5'd9, 16'h0000);
        step();
        chk("flush valid", {31'd0, bus.valid_out}, 32'd0);
        chk("flush instr", bus.Instruction_out, 32'd0);
        chk("flush pc", bus.PC_out, 32'd6);
        chk("flush taken", {31'd0, bus.Branch_taken}, 32'd0);
        a_i = mk(6'd0, 5'd1, 5'd2, 16'h1800);
        bus.PC_in          = 32'd2;
        bus.Instruction_in = a_i;
        step();
        chk("post-flush instr", bus.Instruction_out, a_i);
        chk("post-flush valid", {31'd0, bus.valid_out}, 32'd1);
        chk("post-flush pc", bus.PC_out, 32'd2);

        // Load-use: one stall cycle, then the same ADD issues.
        clr_side();
        a_i = mk(6'd0, 5'd3, 5'd1, 16'h0000);
        b_i = mk(6'd0, 5'd1, 5'd2, 16'h0000);
        bus.PC_in          = 32'd7;
        bus.Instruction_in = a_i;
        step();
        bus.ex_mem_read = 1'b1;
        bus.ex_dest     = 5'd3;
        #1;
        chk("lu freeze", {31'd0, bus.freeze}, 32'd1);
        chk("lu valid", {31'd0, bus.valid_out}, 32'd0);
        chk("lu instr", bus.Instruction_out, 32'd0);
        bus.PC_in          = 32'd8;
        bus.Instruction_in = b_i;
        step();
        bus.ex_mem_read  = 1'b0;
        bus.mem_mem_read = 1'b1;
        bus.mem_dest     = 5'd3;
        #1;
        chk("lu2 freeze", {31'd0, bus.freeze}, 32'd0);
        chk("lu2 instr", bus.Instruction_out, a_i);
        chk("lu2 pc", bus.PC_out, 32'd7);
        step();
        chk("lu3 instr", bus.Instruction_out, b_i);
        chk("lu3 pc", bus.PC_out, 32'd8);

        // Load r4 then BNE r4,r5: two stall cycles, resolve on the third.
        clr_side();
        c_i = mk(6'd11, 5'd4, 5'd5, 16'hFFF0);
        bus.PC_in          = 32'd20;
        bus.Instruction_in = c_i;
        step();
        bus.ex_mem_read  = 1'b1;
        bus.ex_reg_write = 1'b1;
        bus.ex_dest      = 5'd4;
        bus.rs_val       = 32'd4;
        bus.rt_val       = 32'd5;
        #1;
        chk("ldbr c1 freeze", {31'd0, bus.freeze}, 32'd1);
        chk("ldbr c1 taken", {31'd0, bus.Branch_taken}, 32'd0);
        bus.PC_in          = 32'd21;
        bus.Instruction_in = mk(6'd0, 5'd1, 5'd1, 16'h0000);
        step();
        bus.ex_mem_read  = 1'b0;
        bus.ex_reg_write = 1'b0;
        bus.mem_mem_read = 1'b1;
        bus.mem_dest     = 5'd4;
        #1;
        chk("ldbr c2 freeze", {31'd0, bus.freeze}, 32'd1);
        chk("ldbr c2 pc", bus.PC_out, 32'd20);
        chk("ldbr c2 taken", {31'd0, bus.Branch_taken}, 32'd0);
        step();
        bus.mem_mem_read = 1'b0;
        #1;
        chk("ldbr c3 freeze", {31'd0, bus.freeze}, 32'd0);
        chk("ldbr c3 taken", {31'd0, bus.Branch_taken}, 32'd1);
        chk("ldbr c3 baddr", bus.BranchAddr, 32'd4);
        chk("ldbr c3 instr", bus.Instruction_out, c_i);
        step();
        chk("ldbr flush valid", {31'd0, bus.valid_out}, 32'd0);
        chk("ldbr flush instr", bus.Instruction_out, 32'd0);
        clr_side();
        d_i = mk(6'd0, 5'd6, 5'd7, 16'h2000);
        bus.PC_in          = 32'd4;
        bus.Instruction_in = d_i;
        step();
        chk("ldbr resume instr", bus.Instruction_out, d_i);
        chk("ldbr resume pc", bus.PC_out, 32'd4);

        // Hazard under ext_stall, then reset in the middle of a stall.
        clr_side();
        a_i = mk(6'd0, 5'd3, 5'd2, 16'h0000);
        bus.PC_in          = 32'd30;
        bus.Instruction_in = a_i;
        step();
        bus.ext_stall   = 1'b1;
        bus.ex_mem_read = 1'b1;
        bus.ex_dest     = 5'd3;
        #1;
        chk("xst freeze", {31'd0, bus.freeze}, 32'd0);
        chk("xst taken", {31'd0, bus.Branch_taken}, 32'd0);
        chk("xst valid", {31'd0, bus.valid_out}, 32'd0);
        bus.PC_in          = 32'd31;
        bus.Instruction_in = mk(6'd12, 5'd0, 5'd0, 16'h0003);
        step();
        chk("xst hold pc", bus.PC_out, 32'd30);
        bus.ext_stall = 1'b0;
        #1;
        chk("stall freeze", {31'd0, bus.freeze}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst freeze", {31'd0, bus.freeze}, 32'd0);
        chk("midrst pc", bus.PC_out, 32'd0);
        chk("midrst valid", {31'd0, bus.valid_out}, 32'd0);
        chk("midrst rs_addr", {27'd0, bus.rs_addr}, 32'd0);
        rst = 1'b1;
        clr_side();
        d_i = mk(6'd0, 5'd8, 5'd9, 16'h4000);
        bus.PC_in          = 32'd40;
        bus.Instruction_in = d_i;
        step();
        chk("after rst instr", bus.Instruction_out, d_i);
        chk("after rst valid", {31'd0, bus.valid_out}, 32'd1);

`ifdef HAZARD_STATS_EN
        // Counters: 3 stall cycles and 2 taken branches, then saturation.
        clr_side();
        rst_pulse();
        chk("cnt rst stall", {16'd0, bus.stall_count}, 32'd0);
        chk("cnt rst flush", {16'd0, bus.flush_count}, 32'd0);
        bus.PC_in          = 32'd50;
        bus.Instruction_in = mk(6'd10, 5'd1, 5'd2, 16'h0000);
        step();
        bus.ex_reg_write = 1'b1;
        bus.ex_dest      = 5'd1;
        repeat (3) step();
        bus.ex_reg_write = 1'b0;
        bus.Instruction_in = mk(6'd12, 5'd0, 5'd0, 16'h0001);
        step();
        step();
        step();
        chk("cnt stall", {16'd0, bus.stall_count}, 32'd3);
        chk("cnt flush", {16'd0, bus.flush_count}, 32'd2);
        clr_side();
        bus.Instruction_in = mk(6'd0, 5'd3, 5'd0, 16'h0000);
        step();
        bus.ex_mem_read = 1'b1;
        bus.ex_dest     = 5'd3;
        repeat (70000) @(posedge clk);
        #1;
        chk("cnt stall sat", {16'd0, bus.stall_count}, 32'h0000FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
